// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for one 8-bit memory port with programmable wait states.
// Optional macro LOCK_EN adds lock0/lock1 inputs that keep the bus with the current owner.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
`ifdef LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_din,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

  state_t      r_state, w_next;
  logic        r_prio, r_owner, r_we;
  logic [3:0]  r_cnt;
  logic        w_grant, w_sel, w_hold, w_own_lock;

`ifdef LOCK_EN
  logic r_locked;
  assign w_hold     = r_locked;
  assign w_own_lock = r_owner ? lock1 : lock0;
`else
  assign w_hold     = 1'b0;
  assign w_own_lock = 1'b0;
`endif

  assign busy = (r_state != IDLE);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_sel   = r_prio;
    case (r_state)
      IDLE: begin
        // While locked only the owner may be granted; the other side waits.
        if (w_hold) begin
          w_sel   = r_owner;
          w_grant = r_owner ? req1 : req0;
        end else if (req0 && req1) begin
          w_sel   = r_prio;
          w_grant = 1'b1;
        end else if (req0 || req1) begin
          w_sel   = req1;
          w_grant = 1'b1;
        end
        if (w_grant) w_next = ACCESS;
      end
      ACCESS:   if (r_cnt == '0) w_next = COMPLETE;
      COMPLETE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      mem_addr <= '0;
      mem_dout <= '0;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
`ifdef LOCK_EN
      r_locked <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (r_state)
        IDLE: if (w_grant) begin
          r_owner  <= w_sel;
          r_we     <= w_sel ? we1 : we0;
          mem_addr <= w_sel ? addr1 : addr0;
          mem_dout <= w_sel ? wdata1 : wdata0;
          mem_we   <= w_sel ? we1 : we0;
          mem_re   <= w_sel ? !we1 : !we0;
          gnt0     <= !w_sel;
          gnt1     <= w_sel;
          r_cnt    <= 4'(WAIT_STATES);
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        COMPLETE: begin
          if (!r_we) rdata <= mem_din;
          ack0   <= !r_owner;
          ack1   <= r_owner;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          r_prio <= w_own_lock ? r_owner : !r_owner;
`ifdef LOCK_EN
          r_locked <= w_own_lock;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
